// File: rtl/instr_trace_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_trace_buf_pkg
// Purpose  : Shared MIPS decode constants (opcode / funct / rt / rs fields),
//            the ERET encoding, fixed mnemonic strings and the trace entry
//            type used by the instruction trace buffer and its decoder.
// Ports    : none (package)
// Config   : TRACE_ASCII_EN selects mnemonic capture in instr_trace_buf.
// Revision : 1.0 - initial release
// ============================================================================
package instr_trace_buf_pkg;

  // Mnemonic names are held right-aligned in an 8-character field.
  localparam int c_NAME_CH = 8;
  localparam int c_NAME_W  = 8 * c_NAME_CH;

  localparam logic [c_NAME_W-1:0] c_STR_NOP = 64'("NOP");
  localparam logic [c_NAME_W-1:0] c_STR_NR  = 64'("N-R");

  localparam logic [31:0] c_ERET_WORD = 32'h4200_0018;

  // Primary opcodes
  localparam logic [5:0] c_OP_SPECIAL = 6'h00, c_OP_REGIMM = 6'h01, c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL     = 6'h03, c_OP_BEQ    = 6'h04, c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_BLEZ    = 6'h06, c_OP_BGTZ   = 6'h07, c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_ADDIU   = 6'h09, c_OP_SLTI   = 6'h0A, c_OP_SLTIU = 6'h0B;
  localparam logic [5:0] c_OP_ANDI    = 6'h0C, c_OP_ORI    = 6'h0D, c_OP_XORI  = 6'h0E;
  localparam logic [5:0] c_OP_LUI     = 6'h0F, c_OP_COP0   = 6'h10, c_OP_LB    = 6'h20;
  localparam logic [5:0] c_OP_LH      = 6'h21, c_OP_LWL    = 6'h22, c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_LBU     = 6'h24, c_OP_LHU    = 6'h25, c_OP_LWR   = 6'h26;
  localparam logic [5:0] c_OP_SB      = 6'h28, c_OP_SH     = 6'h29, c_OP_SWL   = 6'h2A;
  localparam logic [5:0] c_OP_SW      = 6'h2B, c_OP_SWR    = 6'h2E;

  // SPECIAL funct codes
  localparam logic [5:0] c_FN_SLL   = 6'h00, c_FN_SRL   = 6'h02, c_FN_SRA     = 6'h03;
  localparam logic [5:0] c_FN_SLLV  = 6'h04, c_FN_SRLV  = 6'h06, c_FN_SRAV    = 6'h07;
  localparam logic [5:0] c_FN_JR    = 6'h08, c_FN_JALR  = 6'h09, c_FN_SYSCALL = 6'h0C;
  localparam logic [5:0] c_FN_BREAK = 6'h0D, c_FN_MFHI  = 6'h10, c_FN_MTHI    = 6'h11;
  localparam logic [5:0] c_FN_MFLO  = 6'h12, c_FN_MTLO  = 6'h13, c_FN_MULT    = 6'h18;
  localparam logic [5:0] c_FN_MULTU = 6'h19, c_FN_DIV   = 6'h1A, c_FN_DIVU    = 6'h1B;
  localparam logic [5:0] c_FN_ADD   = 6'h20, c_FN_ADDU  = 6'h21, c_FN_SUB     = 6'h22;
  localparam logic [5:0] c_FN_SUBU  = 6'h23, c_FN_AND   = 6'h24, c_FN_OR      = 6'h25;
  localparam logic [5:0] c_FN_XOR   = 6'h26, c_FN_NOR   = 6'h27, c_FN_SLT     = 6'h2A;
  localparam logic [5:0] c_FN_SLTU  = 6'h2B;

  // REGIMM rt codes
  localparam logic [4:0] c_RT_BLTZ   = 5'h00, c_RT_BGEZ   = 5'h01;
  localparam logic [4:0] c_RT_BLTZAL = 5'h10, c_RT_BGEZAL = 5'h11;

  // COP0 rs codes
  localparam logic [4:0] c_RS_MFC0 = 5'h00, c_RS_MTC0 = 5'h04;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/instr_trace_buf_mnem_dec.sv
`default_nettype none
// ============================================================================
// Module   : mnem_dec
// Purpose  : Combinational MIPS mnemonic decoder. Produces the mnemonic of
//            i_instr as right-aligned ASCII, upper bytes zero, truncated to
//            the leftmost CHARS characters when the name is longer.
// Ports    : i_instr  [31:0]      instruction word
//            o_ascii  [8*CHARS-1:0] mnemonic
// Config   : only built when TRACE_ASCII_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef TRACE_ASCII_EN
module mnem_dec
  import instr_trace_buf_pkg::*;
#(
  parameter int CHARS = 6
) (
  input  logic [31:0]        i_instr,
  output logic [8*CHARS-1:0] o_ascii
);

  localparam int c_TW = (8 * CHARS > c_NAME_W) ? 8 * CHARS : c_NAME_W;

  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic [4:0]          w_rs;
  logic [4:0]          w_rt;
  logic [c_NAME_W-1:0] w_name;
  logic [c_TW-1:0]     w_tmp;
  int                  w_len;
  int                  w_shift;

  assign w_op    = i_instr[31:26];
  assign w_rs    = i_instr[25:21];
  assign w_rt    = i_instr[20:16];
  assign w_funct = i_instr[5:0];

  always_comb begin
    w_name = c_STR_NR;
    // The all-zero word is SLL $0,$0,0; it is reported as NOP first.
    if (i_instr == 32'h0) begin
      w_name = c_STR_NOP;
    end else if (i_instr == c_ERET_WORD) begin
      w_name = 64'("ERET");
    end else begin
      case (w_op)
        c_OP_SPECIAL: begin
          case (w_funct)
            c_FN_SLL:     w_name = 64'("SLL");
            c_FN_SRL:     w_name = 64'("SRL");
            c_FN_SRA:     w_name = 64'("SRA");
            c_FN_SLLV:    w_name = 64'("SLLV");
            c_FN_SRLV:    w_name = 64'("SRLV");
            c_FN_SRAV:    w_name = 64'("SRAV");
            c_FN_JR:      w_name = 64'("JR");
            c_FN_JALR:    w_name = 64'("JALR");
            c_FN_SYSCALL: w_name = 64'("SYSCALL");
            c_FN_BREAK:   w_name = 64'("BREAK");
            c_FN_MFHI:    w_name = 64'("MFHI");
            c_FN_MTHI:    w_name = 64'("MTHI");
            c_FN_MFLO:    w_name = 64'("MFLO");
            c_FN_MTLO:    w_name = 64'("MTLO");
            c_FN_MULT:    w_name = 64'("MULT");
            c_FN_MULTU:   w_name = 64'("MULTU");
            c_FN_DIV:     w_name = 64'("DIV");
            c_FN_DIVU:    w_name = 64'("DIVU");
            c_FN_ADD:     w_name = 64'("ADD");
            c_FN_ADDU:    w_name = 64'("ADDU");
            c_FN_SUB:     w_name = 64'("SUB");
            c_FN_SUBU:    w_name = 64'("SUBU");
            c_FN_AND:     w_name = 64'("AND");
            c_FN_OR:      w_name = 64'("OR");
            c_FN_XOR:     w_name = 64'("XOR");
            c_FN_NOR:     w_name = 64'("NOR");
            c_FN_SLT:     w_name = 64'("SLT");
            c_FN_SLTU:    w_name = 64'("SLTU");
            default:      w_name = c_STR_NR;
          endcase
        end
        c_OP_REGIMM: begin
          case (w_rt)
            c_RT_BLTZ:   w_name = 64'("BLTZ");
            c_RT_BGEZ:   w_name = 64'("BGEZ");
            c_RT_BLTZAL: w_name = 64'("BLTZAL");
            c_RT_BGEZAL: w_name = 64'("BGEZAL");
            default:     w_name = c_STR_NR;
          endcase
        end
        c_OP_COP0: begin
          if (w_rs == c_RS_MFC0)      w_name = 64'("MFC0");
          else if (w_rs == c_RS_MTC0) w_name = 64'("MTC0");
          else                        w_name = c_STR_NR;
        end
        c_OP_J:     w_name = 64'("J");
        c_OP_JAL:   w_name = 64'("JAL");
        c_OP_BEQ:   w_name = 64'("BEQ");
        c_OP_BNE:   w_name = 64'("BNE");
        c_OP_BLEZ:  w_name = 64'("BLEZ");
        c_OP_BGTZ:  w_name = 64'("BGTZ");
        c_OP_ADDI:  w_name = 64'("ADDI");
        c_OP_ADDIU: w_name = 64'("ADDIU");
        c_OP_SLTI:  w_name = 64'("SLTI");
        c_OP_SLTIU: w_name = 64'("SLTIU");
        c_OP_ANDI:  w_name = 64'("ANDI");
        c_OP_ORI:   w_name = 64'("ORI");
        c_OP_XORI:  w_name = 64'("XORI");
        c_OP_LUI:   w_name = 64'("LUI");
        c_OP_LB:    w_name = 64'("LB");
        c_OP_LH:    w_name = 64'("LH");
        c_OP_LWL:   w_name = 64'("LWL");
        c_OP_LW:    w_name = 64'("LW");
        c_OP_LBU:   w_name = 64'("LBU");
        c_OP_LHU:   w_name = 64'("LHU");
        c_OP_LWR:   w_name = 64'("LWR");
        c_OP_SB:    w_name = 64'("SB");
        c_OP_SH:    w_name = 64'("SH");
        c_OP_SWL:   w_name = 64'("SWL");
        c_OP_SW:    w_name = 64'("SW");
        c_OP_SWR:   w_name = 64'("SWR");
        default:    w_name = c_STR_NR;
      endcase
    end
  end

  // Truncation keeps the leftmost characters: drop the excess low bytes.
  always_comb begin
    w_len = 0;
    for (int i = 0; i < c_NAME_CH; i++) begin
      if (w_name[8*i +: 8] != 8'h00) w_len = i + 1;
    end
    w_shift = (w_len > CHARS) ? 8 * (w_len - CHARS) : 0;
    w_tmp   = c_TW'(w_name) >> w_shift;
    o_ascii = w_tmp[8*CHARS-1:0];
  end

endmodule
`endif
`default_nettype wire

// File: rtl/instr_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : instr_trace_buf
// Purpose  : Circular trace buffer of retired instructions with show-ahead
//            read port, overflow policy (overwrite oldest / drop newest) and
//            capture freeze on exception.
// Ports    : i_clk, i_resetn (async, active low)
//            i_wr_valid, i_wr_pc, i_wr_instr, i_wr_exc  - retire capture
//            i_freeze_clr                                - release freeze
//            i_rd_ready, o_rd_valid, o_rd_pc, o_rd_instr, o_rd_ascii - head
//            o_count, o_overflow, o_frozen               - status
// Config   : TRACE_ASCII_EN - store a decoded mnemonic per entry; otherwise
//            o_rd_ascii is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module instr_trace_buf
  import instr_trace_buf_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int CHARS     = 6,
  parameter int OVERWRITE = 1
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic                     i_wr_valid,
  input  logic [31:0]              i_wr_pc,
  input  logic [31:0]              i_wr_instr,
  input  logic                     i_wr_exc,
  input  logic                     i_freeze_clr,
  input  logic                     i_rd_ready,
  output logic                     o_rd_valid,
  output logic [31:0]              o_rd_pc,
  output logic [31:0]              o_rd_instr,
  output logic [8*CHARS-1:0]       o_rd_ascii,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_frozen
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam bit c_OW = (OVERWRITE != 0);

  trace_entry_t    r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic            r_overflow;
  logic            r_frozen;

  logic w_accept;
  logic w_full;
  logic w_pop;
  logic w_lost;
  logic w_store;
  logic w_rd_adv;

  always_comb begin
    w_accept = i_wr_valid & ~r_frozen;
    w_full   = (r_count == c_CW'(DEPTH));
    w_pop    = o_rd_valid & i_rd_ready;
    // A write to a full buffer loses an entry only when no pop frees a slot.
    w_lost   = w_accept & w_full & ~w_pop;
    w_store  = w_accept & (~w_full | w_pop | c_OW);
    // Overwrite mode evicts the oldest entry by moving the head past it.
    w_rd_adv = w_pop | (w_lost & c_OW);
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_frozen   <= 1'b0;
    end else begin
      if (w_store)  r_wr_ptr <= r_wr_ptr + c_AW'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({w_store, w_rd_adv})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
      // A loss in the same cycle as freeze_clr is still recorded.
      if (w_lost)            r_overflow <= 1'b1;
      else if (i_freeze_clr) r_overflow <= 1'b0;
      // The excepting instruction keeps capture halted even against a clear.
      if (w_accept && i_wr_exc) r_frozen <= 1'b1;
      else if (i_freeze_clr)    r_frozen <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_store) begin
      r_mem[r_wr_ptr].pc    <= i_wr_pc;
      r_mem[r_wr_ptr].instr <= i_wr_instr;
    end
  end

  assign o_rd_valid = (r_count != '0);
  assign o_rd_pc    = o_rd_valid ? r_mem[r_rd_ptr].pc    : '0;
  assign o_rd_instr = o_rd_valid ? r_mem[r_rd_ptr].instr : '0;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_frozen   = r_frozen;

`ifdef TRACE_ASCII_EN
  logic [8*CHARS-1:0] w_wr_ascii;
  logic [8*CHARS-1:0] r_ascii_mem [DEPTH];

  mnem_dec #(
    .CHARS (CHARS)
  ) u_mnem_dec (
    .i_instr (i_wr_instr),
    .o_ascii (w_wr_ascii)
  );

  always_ff @(posedge i_clk) begin
    if (w_store) r_ascii_mem[r_wr_ptr] <= w_wr_ascii;
  end

  assign o_rd_ascii = o_rd_valid ? r_ascii_mem[r_rd_ptr] : '0;
`else
  assign o_rd_ascii = '0;
`endif

endmodule
`default_nettype wire
